// File: rtl/mux4_scan_sampler.sv
// rtl/mux4_scan_sampler.sv - scans a 4:1 mux channel by channel and packs the samples into a 4-bit frame
// Optional macro MUX4_SCAN_PARITY_EN adds the frame_par output.
module mux4_scan_sampler #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned DCW   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       s0,
   output logic       s1,
   input  logic       mux_out,
   output logic [3:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
`ifdef MUX4_SCAN_PARITY_EN
   output logic       frame_par,
`endif
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

   state_t         state_q, state_d;
   logic [1:0]     chan_q, chan_d;
   logic [DCW-1:0] dwell_q, dwell_d;
   logic [2:0]     shadow_q, shadow_d;
   logic [3:0]     frame_q, frame_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         chan_q   <= 2'd0;
         dwell_q  <= '0;
         shadow_q <= 3'd0;
         frame_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         dwell_q  <= dwell_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      dwell_d  = dwell_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               chan_d  = 2'd0;
               dwell_d = '0;
            end
         end
         SETTLE: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               chan_d  = chan_q + 2'd1;
               // Channel 3 goes straight into the frame, so the shadow only needs channels 0..2.
               unique case (chan_q)
                  2'd0: shadow_d[0] = mux_out;
                  2'd1: shadow_d[1] = mux_out;
                  2'd2: shadow_d[2] = mux_out;
                  default: begin
                     frame_d = {mux_out, shadow_q};
                     state_d = HOLD;
                  end
               endcase
            end else begin
               dwell_d = dwell_q + DCW'(1);
            end
         end
         HOLD: begin
            if (frame_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign {s1, s0}    = (state_q == SETTLE) ? chan_q : 2'b00;
   assign busy        = (state_q != IDLE);
   assign frame_valid = (state_q == HOLD);
   assign frame       = frame_q;

`ifdef MUX4_SCAN_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= ^frame_d;
      end
   end

   assign frame_par = par_q;
`endif

endmodule
